bitop_stream: RTL

//   Parametrised streaming bitwise-logic unit, successor to the 1-bit XOR top.

---
 rtl/bitop_stream.sv | 115 +++++++++++
 1 files changed

// File: rtl/bitop_stream.sv
// bitop_stream: streaming bitwise-logic unit with an optional framed XOR
// accumulator, a DEPTH-entry result FIFO and a delivered-beat counter.
module bitop_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [1:0]                 in_op,
    input  logic                       in_acc,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_parity,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           beat_cnt,
    input  logic                       trace_en
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    // Each FIFO entry carries the result with its frame-end flag in bit 0.
    logic [WIDTH:0]     mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic               in_fire;
    logic               out_fire;
    logic [WIDTH-1:0]   res;

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Handshakes and the combinational result; a full FIFO never takes a beat,
    // even when the head is popped in the same cycle.
    always_comb begin
        in_ready  = reset & (occ != OCC_W'(DEPTH));
        out_valid = (occ != '0);
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        res       = apply_op(in_op, in_a, in_b) ^ (in_acc ? acc : '0);
    end

    // Head of FIFO is forced to zero when nothing is buffered.
    always_comb begin
        out_data   = out_valid ? mem[rd_ptr][WIDTH:1] : '0;
        out_last   = out_valid & mem[rd_ptr][0];
        out_parity = ^out_data;
        occupancy  = occ;
        beat_cnt   = cnt;
    end

    // FIFO storage is data only and is not reset; occupancy gates validity.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            mem[wr_ptr] <= {res, in_last};
        end
    end

    // Control state: pointers, occupancy, accumulator and beat counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            if (in_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (in_acc) begin
                    acc <= in_last ? '0 : res;
                end
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            case ({in_fire, out_fire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Simulation trace of each delivered beat, tagged with the pre-increment count.
    always @(posedge clock) begin
        if (trace_en && out_fire && reset) begin
            $display("beat=%d data=%h last=%d", cnt, out_data, out_last);
        end
    end
`endif

endmodule
